// File: rtl/fc_layer_ctrl.sv
// Sequencer for one fully-connected layer: streams activations to the neurons, then serialises their results.
// Latency: handshake at edge t -> mem_addr_o in t+1, sum_en_o in t+2; valid_o from t+4+LU_LATENCY after the last word.
// Backpressure: ready_o only in ACCEPT; output words hold on data_o until valid_o & ready_i.
//
// Optional feature macro: FC_LAYER_CTRL_RELU_EN (captured words clamped to max(word, 0)).
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   valid_i/ready_o/data_i    input activation stream
//   mem_addr_o                ROM address broadcast (0..H-1 weights, H bias)
//   sum_en_o/add_bias_o       neuron accumulate / finalise strobes
//   neuron_data_o             activation broadcast, aligned with sum_en_o
//   neuron_sum_i              neuron results, neuron j at [j*WORD_SIZE +: WORD_SIZE]
//   valid_o/ready_i/data_o    output stream, neuron 0 first
module fc_layer_ctrl #(
  parameter int WORD_SIZE             = 16,
  parameter int INT_BITS              = 8,
  parameter int PREVIOUS_LAYER_HEIGHT = 4,
  parameter int LAYER_HEIGHT          = 2,
  parameter int LU_LATENCY            = 1
) (
  input  logic                                         clk_i,
  input  logic                                         reset_i,
  input  logic                                         valid_i,
  output logic                                         ready_o,
  input  logic [WORD_SIZE-1:0]                         data_i,
  output logic [$clog2(PREVIOUS_LAYER_HEIGHT+1)-1:0]   mem_addr_o,
  output logic                                         sum_en_o,
  output logic                                         add_bias_o,
  output logic [WORD_SIZE-1:0]                         neuron_data_o,
  input  logic [LAYER_HEIGHT*WORD_SIZE-1:0]            neuron_sum_i,
  output logic                                         valid_o,
  input  logic                                         ready_i,
  output logic [WORD_SIZE-1:0]                         data_o
);

  localparam int ADDR_W = $clog2(PREVIOUS_LAYER_HEIGHT + 1);
  localparam int IDX_W  = (LAYER_HEIGHT > 1) ? $clog2(LAYER_HEIGHT) : 1;
  localparam int WAIT_W = (LU_LATENCY > 0) ? $clog2(LU_LATENCY + 1) : 1;

  localparam logic [ADDR_W-1:0] LAST_K    = ADDR_W'(PREVIOUS_LAYER_HEIGHT - 1);
  localparam logic [ADDR_W-1:0] BIAS_ADDR = ADDR_W'(PREVIOUS_LAYER_HEIGHT);
  localparam logic [ADDR_W-1:0] K_ONE     = ADDR_W'(1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LAYER_HEIGHT - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(LU_LATENCY);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  // Sign bit sits at the top of the integer field of the fixed-point word.
  localparam int FRAC_BITS = WORD_SIZE - INT_BITS;
  localparam int SIGN_BIT  = INT_BITS + FRAC_BITS - 1;

`ifdef FC_LAYER_CTRL_RELU_EN
  localparam bit RELU_EN = 1'b1;
`else
  localparam bit RELU_EN = 1'b0;
`endif

  localparam logic [2:0] ST_ACCEPT    = 3'd0;
  localparam logic [2:0] ST_BIAS_ADDR = 3'd1;
  localparam logic [2:0] ST_BIAS_ADD  = 3'd2;
  localparam logic [2:0] ST_WAIT      = 3'd3;
  localparam logic [2:0] ST_DRAIN     = 3'd4;

  logic [2:0]           state;
  logic [ADDR_W-1:0]    k_cnt;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_nxt;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [WORD_SIZE-1:0] act_q;
  logic                 act_vld_q;
  logic                 in_hs;
  logic [WORD_SIZE-1:0] out_buf  [LAYER_HEIGHT];
  logic [WORD_SIZE-1:0] cap_word [LAYER_HEIGHT];

  // Gated with reset_i so the stream sees ready low for the whole reset pulse.
  assign ready_o = (state == ST_ACCEPT) && !reset_i;
  assign in_hs   = valid_i && ready_o;
  assign idx_nxt = idx + IDX_ONE;

  // Word actually stored for each neuron: raw, or clamped at zero when ReLU is built in.
  always_comb begin
    for (int j = 0; j < LAYER_HEIGHT; j++) begin
      cap_word[j] = (RELU_EN && neuron_sum_i[j*WORD_SIZE + SIGN_BIT])
                    ? '0 : neuron_sum_i[j*WORD_SIZE +: WORD_SIZE];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state         <= ST_ACCEPT;
      k_cnt         <= '0;
      idx           <= '0;
      wait_cnt      <= '0;
      act_q         <= '0;
      act_vld_q     <= 1'b0;
      mem_addr_o    <= '0;
      sum_en_o      <= 1'b0;
      add_bias_o    <= 1'b0;
      neuron_data_o <= '0;
      valid_o       <= 1'b0;
      data_o        <= '0;
      for (int j = 0; j < LAYER_HEIGHT; j++) begin
        out_buf[j] <= '0;
      end
    end else begin
      // Two-stage operand pipeline: the neurons' ROM is read with the address
      // one cycle before the matching activation and sum_en arrive.
      act_vld_q     <= in_hs;
      sum_en_o      <= act_vld_q;
      neuron_data_o <= act_q;
      add_bias_o    <= 1'b0;
      if (in_hs) begin
        act_q <= data_i;
      end

      case (state)
        ST_ACCEPT: begin
          if (in_hs) begin
            mem_addr_o <= k_cnt;
            if (k_cnt == LAST_K) begin
              k_cnt <= '0;
              state <= ST_BIAS_ADDR;
            end else begin
              k_cnt <= k_cnt + K_ONE;
            end
          end
        end

        // Last weight address is on the bus this cycle; queue the bias address,
        // which overlaps the final sum_en cycle.
        ST_BIAS_ADDR: begin
          mem_addr_o <= BIAS_ADDR;
          state      <= ST_BIAS_ADD;
        end

        ST_BIAS_ADD: begin
          add_bias_o <= 1'b1;
          wait_cnt   <= '0;
          state      <= ST_WAIT;
        end

        // First WAIT cycle is the add_bias cycle itself; the following
        // LU_LATENCY cycles let the neuron results settle before capture.
        ST_WAIT: begin
          if (wait_cnt == LAST_WAIT) begin
            for (int j = 0; j < LAYER_HEIGHT; j++) begin
              out_buf[j] <= cap_word[j];
            end
            data_o  <= cap_word[0];
            valid_o <= 1'b1;
            idx     <= '0;
            state   <= ST_DRAIN;
          end else begin
            wait_cnt <= wait_cnt + WAIT_ONE;
          end
        end

        ST_DRAIN: begin
          if (ready_i) begin
            if (idx == LAST_IDX) begin
              valid_o    <= 1'b0;
              data_o     <= '0;
              idx        <= '0;
              mem_addr_o <= '0;
              state      <= ST_ACCEPT;
            end else begin
              idx    <= idx_nxt;
              data_o <= out_buf[idx_nxt];
            end
          end
        end

        default: begin
          state <= ST_ACCEPT;
        end
      endcase
    end
  end

endmodule
